// File: rtl/fft_seq_pkg.sv
// Shared types and elaboration-time helpers for the in-place radix-2 DIF FFT sequencer.
// Imported by the bus interface, the address generator and the sequencer top.
package fft_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        FIN
    } fft_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Butterfly distance within a stage: N >> (s + 1).
    function automatic int unsigned step_of(input int unsigned log2n, input int unsigned s);
        return (32'd1 << log2n) >> (s + 32'd1);
    endfunction

    // Number of butterfly groups within a stage: 1 << s.
    function automatic int unsigned groups_of(input int unsigned s);
        return 32'd1 << s;
    endfunction

endpackage

// File: rtl/fft_seq_if.sv
// Bundle of the start/status, data RAM, twiddle ROM and butterfly signals around fft_seq.
// The master side is the sequencer; the slave side is the memory/butterfly environment.
interface fft_seq_if
    import fft_pkg::*;
#(
    parameter int LOG2N = 10,
    parameter int DW    = 64
);

    logic                       start;
    logic                       inverse;
    logic                       busy;
    logic                       done;
    logic [clog2(LOG2N)-1:0]    stage;
    logic                       rd_en;
    logic [LOG2N-1:0]           rd_addr_a;
    logic [LOG2N-1:0]           rd_addr_b;
    logic [DW-1:0]              rd_data_a;
    logic [DW-1:0]              rd_data_b;
    logic [LOG2N-2:0]           tw_addr;
    logic                       tw_conj;
    logic                       btf_valid;
    logic [DW-1:0]              btf_din1;
    logic [DW-1:0]              btf_din2;
    logic [DW-1:0]              btf_dout1;
    logic [DW-1:0]              btf_dout2;
    logic                       wr_en;
    logic [LOG2N-1:0]           wr_addr_a;
    logic [LOG2N-1:0]           wr_addr_b;
    logic [DW-1:0]              wr_data_a;
    logic [DW-1:0]              wr_data_b;

    modport master (
        input  start, inverse, rd_data_a, rd_data_b, btf_dout1, btf_dout2,
        output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr, tw_conj,
               btf_valid, btf_din1, btf_din2, wr_en, wr_addr_a, wr_addr_b,
               wr_data_a, wr_data_b
    );

    modport slave (
        output start, inverse, rd_data_a, rd_data_b, btf_dout1, btf_dout2,
        input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr, tw_conj,
               btf_valid, btf_din1, btf_din2, wr_en, wr_addr_a, wr_addr_b,
               wr_data_a, wr_data_b
    );

endinterface

// File: rtl/fft_seq_addr_gen.sv
// Stage/group/butterfly counters of the in-place DIF schedule and the operand and
// twiddle addresses they imply; all scaling by step/groups is done with shifts.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     adv,
    output logic                     last,
    output logic [clog2(LOG2N)-1:0]  stage,
    output logic [LOG2N-1:0]         addr_a,
    output logic [LOG2N-1:0]         addr_b,
    output logic [LOG2N-2:0]         tw_addr
);

    localparam int SW  = clog2(LOG2N);
    localparam int SHW = clog2(LOG2N + 1);

    logic [LOG2N-2:0] g;
    logic [LOG2N-2:0] k;
    logic [LOG2N-1:0] step;
    logic [LOG2N-1:0] groups;
    logic [SHW-1:0]   span_shift;
    logic             k_last;
    logic             g_last;
    logic             s_last;

    assign step       = LOG2N'(step_of(LOG2N, 32'(stage)));
    assign groups     = LOG2N'(groups_of(32'(stage)));
    assign span_shift = SHW'(LOG2N - int'(stage));

    assign k_last = ({1'b0, k} == step - 1'b1);
    assign g_last = ({1'b0, g} == groups - 1'b1);
    assign s_last = (stage == SW'(LOG2N - 1));
    assign last   = s_last && g_last && k_last;

    // g * 2 * step equals g << (LOG2N - s); the twiddle index k * groups wraps mod N/2 by truncation.
    assign addr_a  = ({1'b0, g} << span_shift) + {1'b0, k};
    assign addr_b  = addr_a + step;
    assign tw_addr = k << stage;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            stage <= '0;
            g     <= '0;
            k     <= '0;
        end else if (adv) begin
            if (!k_last) begin
                k <= k + 1'b1;
            end else begin
                k <= '0;
                if (!g_last) begin
                    g <= g + 1'b1;
                end else begin
                    g     <= '0;
                    stage <= s_last ? '0 : stage + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fft_seq.sv
// In-place radix-2 DIF FFT sequencer: one butterfly in flight, read -> wait BTF_LAT -> write back,
// walking every stage, group and butterfly of an N = 2**LOG2N point transform.
module fft_seq
    import fft_pkg::*;
#(
    parameter int LOG2N   = 10,
    parameter int DW      = 64,
    parameter int BTF_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    fft_seq_if.master   bus
);

    localparam int SW = clog2(LOG2N);
    localparam int LW = clog2(BTF_LAT + 1);

    fft_state_t        state;
    fft_state_t        next_state;
    logic [LW-1:0]     lat_cnt;
    logic              inv_q;
    logic [LOG2N-1:0]  wr_addr_a_q;
    logic [LOG2N-1:0]  wr_addr_b_q;
    logic [LOG2N-1:0]  gen_a;
    logic [LOG2N-1:0]  gen_b;
    logic [LOG2N-2:0]  gen_tw;
    logic [SW-1:0]     gen_stage;
    logic              gen_last;
    logic              clr;
    logic              adv;

    assign clr = (state == IDLE) && bus.start;
    assign adv = (state == WR);

    fft_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .adv     (adv),
        .last    (gen_last),
        .stage   (gen_stage),
        .addr_a  (gen_a),
        .addr_b  (gen_b),
        .tw_addr (gen_tw)
    );

    assign bus.stage   = gen_stage;
    assign bus.tw_conj = inv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Mode latch, write-address capture and the WAIT-phase latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt     <= '0;
            inv_q       <= 1'b0;
            wr_addr_a_q <= '0;
            wr_addr_b_q <= '0;
        end else begin
            if (clr) begin
                inv_q <= bus.inverse;
            end
            if (state == RD) begin
                wr_addr_a_q <= gen_a;
                wr_addr_b_q <= gen_b;
            end
            lat_cnt <= (state == WAIT) ? lat_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        next_state    = state;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_addr_a = '0;
        bus.rd_addr_b = '0;
        bus.tw_addr   = '0;
        bus.btf_valid = 1'b0;
        bus.btf_din1  = '0;
        bus.btf_din2  = '0;
        bus.wr_en     = 1'b0;
        bus.wr_addr_a = '0;
        bus.wr_addr_b = '0;
        bus.wr_data_a = '0;
        bus.wr_data_b = '0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = RD;
                end
            end
            RD: begin
                bus.busy      = 1'b1;
                bus.rd_en     = 1'b1;
                bus.rd_addr_a = gen_a;
                bus.rd_addr_b = gen_b;
                bus.tw_addr   = gen_tw;
                next_state    = WAIT;
            end
            WAIT: begin
                bus.busy = 1'b1;
                if (lat_cnt == '0) begin
                    bus.btf_valid = 1'b1;
                    bus.btf_din1  = bus.rd_data_a;
                    bus.btf_din2  = bus.rd_data_b;
                end
                if (lat_cnt == LW'(BTF_LAT - 1)) begin
                    next_state = WR;
                end
            end
            WR: begin
                bus.busy      = 1'b1;
                bus.wr_en     = 1'b1;
                bus.wr_addr_a = wr_addr_a_q;
                bus.wr_addr_b = wr_addr_b_q;
                bus.wr_data_a = bus.btf_dout1;
                bus.wr_data_b = bus.btf_dout2;
                next_state    = gen_last ? FIN : RD;
            end
            FIN: begin
                bus.done   = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fft_seq.sv
// Self-checking bench for fft_seq (N = 8, BTF_LAT = 3) with a RAM model, a pipelined butterfly
// model and a schedule/transform reference computed directly from the DIF loop definitions.
module tb_fft_seq;

    localparam int LOG2N    = 3;
    localparam int N        = 1 << LOG2N;
    localparam int BTF_LAT  = 3;
    localparam int P        = BTF_LAT + 2;
    localparam int NBFLY    = LOG2N * (N / 2);
    localparam int DONE_CYC = NBFLY * P + 1;

    logic clk;
    logic rst;
    logic load_ram;
    bit   bf_mode;

    logic [63:0] mem     [N];
    logic [63:0] ram_img [N];
    logic [63:0] ram_exp [N];
    logic [63:0] pipe1   [BTF_LAT];
    logic [63:0] pipe2   [BTF_LAT];

    int assertions;
    int failures;

    int rd_cyc[$], rd_a[$], rd_b[$], rd_tw[$], rd_s[$];
    int vld_cyc[$], wr_cyc[$], wr_a[$], wr_b[$], done_cyc[$];
    int busy_cnt, busy_first, busy_last, conj_bad, wr_after_abort, done_after_abort;

    fft_seq_if #(.LOG2N(LOG2N), .DW(64)) bus ();

    fft_seq #(
        .LOG2N   (LOG2N),
        .DW      (64),
        .BTF_LAT (BTF_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port data RAM: registered read one cycle after rd_en, write on wr_en.
    always @(posedge clk) begin
        if (load_ram) begin
            for (int i = 0; i < N; i++) mem[i] <= ram_img[i];
        end else begin
            if (bus.rd_en) begin
                bus.rd_data_a <= mem[bus.rd_addr_a];
                bus.rd_data_b <= mem[bus.rd_addr_b];
            end
            if (bus.wr_en) begin
                mem[bus.wr_addr_a] <= bus.wr_data_a;
                mem[bus.wr_addr_b] <= bus.wr_data_b;
            end
        end
    end

    // Butterfly with BTF_LAT cycles of latency: loopback, or sum/difference with unit twiddles.
    always @(posedge clk) begin
        for (int i = BTF_LAT - 1; i > 0; i--) begin
            pipe1[i] <= pipe1[i-1];
            pipe2[i] <= pipe2[i-1];
        end
        if (bus.btf_valid) begin
            pipe1[0] <= bf_mode ? bus.btf_din1 + bus.btf_din2 : bus.btf_din1;
            pipe2[0] <= bf_mode ? bus.btf_din1 - bus.btf_din2 : bus.btf_din2;
        end else begin
            pipe1[0] <= '0;
            pipe2[0] <= '0;
        end
    end

    assign bus.btf_dout1 = pipe1[BTF_LAT-1];
    assign bus.btf_dout2 = pipe2[BTF_LAT-1];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assertions++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Loads random RAM contents and derives the expected final RAM for the chosen butterfly.
    // With unit twiddles and sum/difference butterflies the in-place DIF walk is a Walsh-Hadamard
    // transform: X[j] = sum_i (-1)^popcount(i & j) * x[i].
    task automatic prepareRam(input bit mode);
        logic [63:0] acc;
        for (int i = 0; i < N; i++) ram_img[i] = {$urandom, $urandom};
        for (int j = 0; j < N; j++) begin
            if (mode) begin
                acc = '0;
                for (int i = 0; i < N; i++) begin
                    if ($countones(i & j) % 2 == 1) acc = acc - ram_img[i];
                    else                            acc = acc + ram_img[i];
                end
                ram_exp[j] = acc;
            end else begin
                ram_exp[j] = ram_img[j];
            end
        end
        bf_mode = mode;
        @(negedge clk);
        load_ram = 1'b1;
        @(negedge clk);
        load_ram = 1'b0;
    endtask

    // Starts a transform (start sampled at edge 0) and records every cycle 1..ncyc.
    task automatic applyStimulus(input bit inv, input int drop_cyc, input int restart_cyc,
                                 input int abort_cyc, input int ncyc);
        rd_cyc.delete(); rd_a.delete(); rd_b.delete(); rd_tw.delete(); rd_s.delete();
        vld_cyc.delete(); wr_cyc.delete(); wr_a.delete(); wr_b.delete(); done_cyc.delete();
        busy_cnt = 0; busy_first = -1; busy_last = -1; conj_bad = 0;
        wr_after_abort = 0; done_after_abort = 0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.inverse = inv;
        @(posedge clk);
        #1;
        for (int c = 1; c <= ncyc; c++) begin
            bus.start = (c == restart_cyc);
            rst       = (c == abort_cyc);
            if (c == drop_cyc) bus.inverse = ~inv;
            if (bus.busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            if (bus.tw_conj !== inv) conj_bad++;
            if (bus.rd_en) begin
                rd_cyc.push_back(c);
                rd_a.push_back(int'(bus.rd_addr_a));
                rd_b.push_back(int'(bus.rd_addr_b));
                rd_tw.push_back(int'(bus.tw_addr));
                rd_s.push_back(int'(bus.stage));
            end
            if (bus.btf_valid) vld_cyc.push_back(c);
            if (bus.wr_en) begin
                wr_cyc.push_back(c);
                wr_a.push_back(int'(bus.wr_addr_a));
                wr_b.push_back(int'(bus.wr_addr_b));
                if (abort_cyc > 0 && c > abort_cyc) wr_after_abort++;
            end
            if (bus.done) begin
                done_cyc.push_back(c);
                if (abort_cyc > 0 && c > abort_cyc) done_after_abort++;
            end
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        rst       = 1'b0;
    endtask

    // Compares the recorded run with the schedule defined by the nested s/g/k loops.
    task automatic checkTimeline(input bit inv);
        int ea[$], eb[$], et[$], es[$];
        int step, groups, t0;
        for (int s = 0; s < LOG2N; s++) begin
            step   = N / (2 ** (s + 1));
            groups = 2 ** s;
            for (int g = 0; g < groups; g++) begin
                for (int k = 0; k < step; k++) begin
                    ea.push_back(g * 2 * step + k);
                    eb.push_back(g * 2 * step + k + step);
                    et.push_back((k * groups) % (N / 2));
                    es.push_back(s);
                end
            end
        end
        checkOutput("rd_count", rd_cyc.size(), NBFLY);
        checkOutput("valid_count", vld_cyc.size(), NBFLY);
        checkOutput("wr_count", wr_cyc.size(), NBFLY);
        for (int i = 0; i < NBFLY; i++) begin
            t0 = 1 + i * P;
            if (i < rd_cyc.size()) begin
                checkOutput($sformatf("rd_cycle[%0d]", i), rd_cyc[i], t0);
                checkOutput($sformatf("rd_addr_a[%0d]", i), rd_a[i], ea[i]);
                checkOutput($sformatf("rd_addr_b[%0d]", i), rd_b[i], eb[i]);
                checkOutput($sformatf("tw_addr[%0d]", i), rd_tw[i], et[i]);
                checkOutput($sformatf("stage[%0d]", i), rd_s[i], es[i]);
            end
            if (i < vld_cyc.size())
                checkOutput($sformatf("valid_cycle[%0d]", i), vld_cyc[i], t0 + 1);
            if (i < wr_cyc.size()) begin
                checkOutput($sformatf("wr_cycle[%0d]", i), wr_cyc[i], t0 + BTF_LAT + 1);
                checkOutput($sformatf("wr_addr_a[%0d]", i), wr_a[i], ea[i]);
                checkOutput($sformatf("wr_addr_b[%0d]", i), wr_b[i], eb[i]);
            end
        end
        checkOutput("done_count", done_cyc.size(), 1);
        if (done_cyc.size() > 0) checkOutput("done_cycle", done_cyc[0], DONE_CYC);
        checkOutput("busy_count", busy_cnt, DONE_CYC - 1);
        checkOutput("busy_first", busy_first, 1);
        checkOutput("busy_last", busy_last, DONE_CYC - 1);
        checkOutput($sformatf("tw_conj_stable(inv=%0d)", inv), conj_bad, 0);
    endtask

    task automatic checkRam(input string tag);
        for (int i = 0; i < N; i++)
            checkOutput($sformatf("%s[%0d]", tag, i), mem[i], ram_exp[i]);
    endtask

    initial begin
        bit inv;
        assertions  = 0;
        failures    = 0;
        rst         = 1'b1;
        load_ram    = 1'b0;
        bf_mode     = 1'b0;
        bus.start   = 1'b0;
        bus.inverse = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_rd_en", bus.rd_en, 0);
        checkOutput("reset_wr_en", bus.wr_en, 0);
        checkOutput("reset_btf_valid", bus.btf_valid, 0);
        checkOutput("reset_tw_conj", bus.tw_conj, 0);
        checkOutput("reset_stage", bus.stage, 0);
        checkOutput("reset_rd_addr_b", bus.rd_addr_b, 0);
        checkOutput("reset_tw_addr", bus.tw_addr, 0);
        checkOutput("reset_wr_addr_b", bus.wr_addr_b, 0);
        checkOutput("reset_wr_data_a", bus.wr_data_a, 0);
        checkOutput("reset_btf_din1", bus.btf_din1, 0);
        rst = 1'b0;

        $display("[TB] loopback run: inverse dropped mid-run, stray start while busy");
        prepareRam(1'b0);
        applyStimulus(1'b1, 20, 30, 0, DONE_CYC + 9);
        checkTimeline(1'b1);
        checkRam("ram_loopback");

        $display("[TB] reset asserted during WAIT");
        prepareRam(1'b0);
        applyStimulus(1'b0, 0, 0, 8, 80);
        checkOutput("abort_wr_before", wr_cyc.size(), 1);
        checkOutput("abort_wr_after", wr_after_abort, 0);
        checkOutput("abort_done_after", done_after_abort, 0);
        checkOutput("abort_done_count", done_cyc.size(), 0);

        $display("[TB] fresh start after reset");
        prepareRam(1'b0);
        applyStimulus(1'b0, 0, 0, 0, DONE_CYC + 9);
        checkTimeline(1'b0);
        checkRam("ram_after_abort");

        for (int r = 0; r < 3; r++) begin
            inv = 1'($urandom_range(0, 1));
            $display("[TB] sum/difference run %0d, inverse=%0d", r, inv);
            prepareRam(1'b1);
            applyStimulus(inv, 0, 0, 0, DONE_CYC + 9);
            checkTimeline(inv);
            checkRam($sformatf("ram_wht%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/fft_seq.md
# fft_seq

Parametrised in-place radix-2 decimation-in-frequency (DIF) FFT sequencer. It generalises the fixed 1024-point controller to any power-of-two size, with programmable butterfly latency and forward/inverse mode. It walks all stages, groups and butterflies. For each butterfly it reads the operand pair from the dual-port data RAM, feeds the butterfly unit, and writes the results back in place. It sits between the data RAM, the twiddle ROM and `btf`.

## Interface
- `LOG2N`, 10, log2 of transform size N (3..12)
- `DW`, 64, complex sample width ({im,re}, DW/2 each)
- `BTF_LAT`, 3, butterfly input-to-output latency in cycles (≥1)
- `clk` in 1: single clock
- `rst` in 1: reset, synchronous, active-high
- `start` in 1: begin transform; sampled only in IDLE
- `inverse` in 1: latched at accepted start; drives `tw_conj`
- `busy` out 1: high from the cycle after accepted start until the last write
- `done` out 1: one-cycle pulse after the last write-back
- `stage` out LOG2N-ish (clog2(LOG2N)): current stage index, for per-stage scaling
- `rd_en` out 1: RAM read strobe
- `rd_addr_a`, `rd_addr_b` out LOG2N: read addresses
- `rd_data_a`, `rd_data_b` in DW: RAM read data, valid 1 cycle after `rd_en`
- `tw_addr` out LOG2N-1: twiddle ROM address; ROM latency is 1 cycle
- `tw_conj` out 1: conjugate twiddle (inverse mode)
- `btf_valid` out 1: butterfly inputs valid
- `btf_din1`, `btf_din2` out DW: butterfly inputs
- `btf_dout1`, `btf_dout2` in DW: butterfly outputs
- `wr_en` out 1: RAM write strobe
- `wr_addr_a`, `wr_addr_b` out LOG2N: write addresses
- `wr_data_a`, `wr_data_b` out DW: write data

## Operation
- States: IDLE, RD, WAIT, WR, FIN.
- IDLE + `start` → RD. Latch `inverse` and clear all counters.
- RD (1 cycle):
  - `rd_en`=1.
  - `rd_addr_a` = g·2·step + k; `rd_addr_b` = `rd_addr_a` + step.
  - `tw_addr` = (k·groups) mod N/2.
  - Capture both addresses into write-address registers.
- WAIT (BTF_LAT cycles):
  - On the first WAIT cycle, `btf_valid`=1 and `btf_din1/2` = `rd_data_a/b`, passed combinationally.
  - `btf_valid` is 0 in every other cycle.
- WR (1 cycle):
  - `wr_en`=1, with `wr_data_a/b` = `btf_dout1/2` and the captured addresses.
  - Then advance the counters. If more butterflies remain → RD, else → FIN.
- FIN (1 cycle): `done`=1, `busy`=0 → IDLE.
- Stage s in 0..LOG2N-1:
  - step = N>>(s+1), groups = 1<<s.
  - k in 0..step-1 is the inner loop; g in 0..groups-1 is the middle loop.
  - step/groups are derived from `stage` by shift. No multiplier: the k·groups term is k<<s.
- Counter wrap: k wraps → g++. g wraps → s++ and k=g=0. Last butterfly is s=LOG2N-1, g=groups-1, k=0.
- `start` during busy/FIN is ignored. `inverse` changes mid-run have no effect.
- `rst` in any state → IDLE next cycle. No `wr_en` or `done` follow.

## Timing
- Reset values: `busy`, `done`, `rd_en`, `wr_en`, `btf_valid`, `tw_conj`, `stage` all 0. Addresses and data are 0.
- Butterfly period P = BTF_LAT+2 cycles. Total cycles = LOG2N·(N/2)·P.
- With `start` sampled at edge 0:
  - First RD is in cycle 1.
  - Last WR is in cycle LOG2N·(N/2)·P.
  - `done` is in the following cycle.
- Only one butterfly is in flight at a time, so there are no read-after-write hazards.

## Structure
- Package `fft_pkg`: state enum, `clog2` function, stage-derived step/group helpers.
- Sub-module `fft_addr_gen` holds the s/g/k counters and the a/b/twiddle address generation, with inputs `clr` and `adv` and outputs `last` and `stage`.
- The top level holds the FSM, latency counter, data muxing and address capture.

## Test plan
- LOG2N=3, BTF_LAT=3, start at cycle 0:
  - RD cycles at 1, 6, 11, 16 give (a,b,tw) = (0,4,0), (1,5,1), (2,6,2), (3,7,3).
  - `done` pulses at cycle 61; `busy` is high over cycles 1–60.
- Same configuration, stage 1 sequence = (0,2,0), (1,3,2), (4,6,0), (5,7,2). Stage 2 = (0,1,0), (2,3,0), (4,5,0), (6,7,0).
- Loopback model (`btf_dout` = `btf_din`, RAM model):
  - RAM contents end unchanged.
  - `btf_valid` occurs exactly 1 cycle after each `rd_en`.
  - `wr_en` occurs exactly BTF_LAT+1 cycles after each `rd_en`.
- Start with `inverse`=1, then drop `inverse` mid-run → `tw_conj` stays 1 throughout. A `start` pulse while busy → no restart, and `done` occurs once.
- Assert `rst` during a WAIT cycle → no `wr_en` and no `done` afterwards. A fresh start then reproduces the scenario-1 timeline.
- LOG2N=10, BTF_LAT=1 against a reference FFT model → bins match within ±2 LSB. `done` occurs at cycle 15361.
